pipeline_elastic_chain: RTL and testbench

//  Parametrised multi-stage elastic pipeline with valid/ready handshakes, bubble collapsing,

---
 rtl/pipeline_elastic_chain.sv | 111 +++++++++++
 tb/tb_pipeline_elastic_chain.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pipeline_elastic_chain.sv
// pipeline_elastic_chain: DEPTH-stage elastic valid/ready pipeline with bubble collapsing, flush and optional skid.
// Optional stall counter enabled by defining PIPE_PERF_CNT_EN; otherwise stall_cnt is tied to zero.
module pipeline_elastic_chain #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   parameter int SKID  = 1,
   localparam int OW   = $clog2(DEPTH + SKID + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [OW-1:0]    occupancy,
   output logic [31:0]      stall_cnt
);
   logic [DEPTH-1:0]            valid_q, valid_d;
   logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
   logic [DEPTH:0]              ld;
   logic                        src_valid, in_fire, out_fire;
   logic [WIDTH-1:0]            src_data;
   logic [OW-1:0]               occ_q, occ_d;

   assign out_valid = valid_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];
   assign occupancy = occ_q;
   assign out_fire  = out_valid && out_ready;

   // Load enables ripple from the output back; an empty stage always loads so bubbles collapse.
   always_comb begin
      ld[DEPTH] = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) ld[i] = !valid_q[i] || ld[i+1];
   end

   // Stage advance: valids shift on load, payloads move only when a valid entry moves in.
   always_comb begin
      valid_d[0] = ld[0] ? src_valid : valid_q[0];
      data_d[0]  = (ld[0] && src_valid) ? src_data : data_q[0];
      for (int i = 1; i < DEPTH; i++) begin
         valid_d[i] = ld[i] ? valid_q[i-1] : valid_q[i];
         data_d[i]  = (ld[i] && valid_q[i-1]) ? data_q[i-1] : data_q[i];
      end
      if (flush) valid_d = '0;
      occ_d = flush ? '0 : occ_q + OW'(in_fire) - OW'(out_fire);
   end

   // Stage and occupancy registers; data registers are deliberately kept across flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         data_q  <= '0;
         occ_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         occ_q   <= occ_d;
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         logic             skid_valid_q, skid_valid_d;
         logic [WIDTH-1:0] skid_data_q, skid_data_d;
         // Registered in_ready; a word that stage 0 cannot take parks in skid, which drains first.
         always_comb begin
            in_ready     = !skid_valid_q;
            in_fire      = in_valid && in_ready;
            src_valid    = skid_valid_q || in_fire;
            src_data     = skid_valid_q ? skid_data_q : in_data;
            skid_valid_d = !flush && (skid_valid_q ? !ld[0] : (in_fire && !ld[0]));
            skid_data_d  = (in_fire && !ld[0]) ? in_data : skid_data_q;
         end
         // Skid entry register.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               skid_valid_q <= 1'b0;
               skid_data_q  <= '0;
            end else begin
               skid_valid_q <= skid_valid_d;
               skid_data_q  <= skid_data_d;
            end
         end
      end else begin : g_noskid
         // Without skid, in_ready is combinational from the stage chain and out_ready.
         always_comb begin
            in_ready  = ld[0];
            in_fire   = in_valid && in_ready;
            src_valid = in_fire;
            src_data  = in_data;
         end
      end
   endgenerate

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   // Saturating count of cycles where the output holds data the consumer refuses; flush does not clear it.
   always_comb stall_cnt_d = (out_valid && !out_ready && stall_cnt_q != 32'hFFFF_FFFF) ? stall_cnt_q + 32'd1 : stall_cnt_q;
   // Stall counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end
   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_pipeline_elastic_chain.sv
// tb_pipeline_elastic_chain: directed checks of stream, backpressure, bubble collapse, flush, async reset and stall counter.
module tb_pipeline_elastic_chain;
   logic clk, rst_n;
   int tests = 0, fails = 0;
   logic        a_fl, a_iv, a_ir, a_ov, a_or; logic [15:0] a_id, a_od; logic [2:0] a_occ; logic [31:0] a_sc;
   logic        b_fl, b_iv, b_ir, b_ov, b_or; logic [15:0] b_id, b_od; logic [2:0] b_occ; logic [31:0] b_sc;
   logic        c_fl, c_iv, c_ir, c_ov, c_or; logic [15:0] c_id, c_od; logic [1:0] c_occ; logic [31:0] c_sc;
`ifdef PIPE_PERF_CNT_EN
   localparam logic [31:0] STALL_EXP = 32'd10;
`else
   localparam logic [31:0] STALL_EXP = 32'd0;
`endif

   pipeline_elastic_chain #(.WIDTH(16), .DEPTH(3), .SKID(1)) u_a (
      .clk(clk), .rst_n(rst_n), .flush(a_fl), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
      .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .occupancy(a_occ), .stall_cnt(a_sc));
   pipeline_elastic_chain #(.WIDTH(16), .DEPTH(4), .SKID(0)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(b_fl), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
      .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .occupancy(b_occ), .stall_cnt(b_sc));
   pipeline_elastic_chain #(.WIDTH(16), .DEPTH(2), .SKID(1)) u_c (
      .clk(clk), .rst_n(rst_n), .flush(c_fl), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
      .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .occupancy(c_occ), .stall_cnt(c_sc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      {a_fl, a_iv, a_or, b_fl, b_iv, b_or, c_fl, c_iv, c_or} = '0;
      a_id = '0; b_id = '0; c_id = '0;
      #1;
      chk("rst_a_ov", a_ov, 0); chk("rst_a_occ", a_occ, 0); chk("rst_a_ir", a_ir, 1); chk("rst_a_sc", a_sc, 0);
      chk("rst_b_ir", b_ir, 1); chk("rst_c_ir", c_ir, 1); chk("rst_c_occ", c_occ, 0);
      @(negedge clk); rst_n = 1'b1;
      // stream: DEPTH=3, first word visible after 3rd edge, then 8 words without gaps
      a_or = 1; a_iv = 1; a_id = 16'h1;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         chk("stream_ir", a_ir, 1);
         chk("stream_ov", a_ov, (k >= 3 && k <= 10));
         if (k >= 3 && k <= 10) chk("stream_data", a_od, 64'(k - 2));
         a_iv = (k < 8); a_id = 16'(k + 1);
      end
      chk("stream_occ_end", a_occ, 0);
      // backpressure: 4 accepted, then drain in order and accept 0x14
      a_or = 0; a_iv = 1; a_id = 16'h10;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("bp_occ", a_occ, 64'(k));
         chk("bp_ir", a_ir, (k < 4));
         a_id = 16'(16'h10 + k);
      end
      repeat (2) begin
         @(negedge clk);
         chk("bp_hold_ir", a_ir, 0); chk("bp_hold_occ", a_occ, 4);
         chk("bp_hold_ov", a_ov, 1); chk("bp_hold_data", a_od, 16'h10);
      end
      a_or = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("bp_drain_ov", a_ov, 1);
         chk("bp_drain_data", a_od, 64'(16'h11 + k));
         if (k == 0) chk("bp_ir_back", a_ir, 1);
         a_iv = (k == 0);
      end
      @(negedge clk);
      chk("bp_empty_ov", a_ov, 0); chk("bp_empty_occ", a_occ, 0);
      // bubble collapse: DEPTH=4, SKID=0
      b_iv = 1; b_id = 16'hA;
      @(negedge clk); b_iv = 0;
      @(negedge clk);
      @(negedge clk); chk("bub_ir", b_ir, 1); b_iv = 1; b_id = 16'hB;
      @(negedge clk); b_iv = 0;
      chk("bub_ov", b_ov, 1); chk("bub_data", b_od, 16'hA); chk("bub_occ2", b_occ, 2);
      repeat (3) @(negedge clk);
      chk("bub_settled_occ", b_occ, 2); chk("bub_settled_data", b_od, 16'hA); chk("bub_settled_ir", b_ir, 1);
      b_or = 1;
      @(negedge clk); chk("bub_rel_ov", b_ov, 1); chk("bub_rel_data", b_od, 16'hB);
      @(negedge clk); chk("bub_done_ov", b_ov, 0); chk("bub_done_occ", b_occ, 0);
      // flush: DEPTH=2 chain full with skid, flush while offering 0xDEAD
      c_iv = 1; c_id = 16'h1;
      @(negedge clk); c_id = 16'h2;
      @(negedge clk); c_id = 16'h3;
      @(negedge clk);
      chk("fl_full_occ", c_occ, 3); chk("fl_full_ir", c_ir, 0); chk("fl_full_data", c_od, 16'h1);
      c_fl = 1; c_id = 16'hDEAD;
      @(negedge clk);
      chk("fl_ov", c_ov, 0); chk("fl_occ", c_occ, 0); chk("fl_ir", c_ir, 1);
      c_fl = 0; c_iv = 0; c_or = 1;
      repeat (3) begin @(negedge clk); chk("fl_quiet_ov", c_ov, 0); end
      c_iv = 1; c_id = 16'h77;
      @(negedge clk); c_iv = 0; chk("fl_post_lat", c_ov, 0);
      @(negedge clk); chk("fl_post_ov", c_ov, 1); chk("fl_post_data", c_od, 16'h77);
      @(negedge clk); chk("fl_post_empty", c_ov, 0);
      // async reset mid-stream
      a_or = 0; a_iv = 1; a_id = 16'h21;
      @(negedge clk); a_id = 16'h22;
      @(negedge clk); a_id = 16'h23;
      @(negedge clk); a_iv = 0;
      chk("ar_pre_ov", a_ov, 1); chk("ar_pre_occ", a_occ, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_ov", a_ov, 0); chk("ar_occ", a_occ, 0); chk("ar_ir", a_ir, 1);
      @(negedge clk); rst_n = 1'b1;
      a_or = 1; a_iv = 1; a_id = 16'h55;
      @(negedge clk); a_iv = 0; chk("ar_55_lat1", a_ov, 0);
      @(negedge clk); chk("ar_55_lat2", a_ov, 0);
      @(negedge clk); chk("ar_55_ov", a_ov, 1); chk("ar_55_data", a_od, 16'h55);
      @(negedge clk); chk("ar_55_gone", a_ov, 0);
      // stall counter: 10 stall cycles then flush with out_ready=1
      a_or = 0; a_iv = 1; a_id = 16'h99;
      @(negedge clk); a_iv = 0;
      @(negedge clk);
      @(negedge clk); chk("pc_ov", a_ov, 1); chk("pc_sc0", a_sc, 0);
      repeat (10) @(negedge clk);
      chk("pc_sc_stall", a_sc, STALL_EXP);
      a_fl = 1; a_or = 1;
      @(negedge clk); a_fl = 0; a_or = 0;
      chk("pc_sc_flush", a_sc, STALL_EXP); chk("pc_fl_ov", a_ov, 0); chk("pc_fl_occ", a_occ, 0);
      @(negedge clk); chk("pc_sc_after", a_sc, STALL_EXP);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
